wave_gen: RTL and testbench
===========================

WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter OUT_W, 8, sample width in bits; SHALL satisfy OUT_W >= STEP_BITS+1.
REQ-002 Parameter STEP_BITS, 4, log2 of steps per waveform cycle (N = 2^STEP_BITS); SHALL be >= 2.
REQ-003 Parameter PERIOD_W, 32, width of the period input.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  run enable; low SHALL hold the generator idle.
REQ-007 cfg_valid  input  1  config offer; transfer occurs when cfg_valid && cfg_ready.
REQ-008 cfg_ready  output  1  high when no pending config is waiting to be applied.
REQ-009 cfg_period  input  PERIOD_W  cycle length in clocks; step length L = cfg_period >> STEP_BITS.
REQ-010 cfg_mode  input  2  0 triangle, 1 rising saw, 2 square, 3 falling saw.
REQ-011 cfg_duty  input  STEP_BITS  square high-step count.
REQ-012 value  output  OUT_W  registered sample.
REQ-013 cycle_start  output  1  one-clock pulse marking the first sample of each cycle.

Function
REQ-014 Active config (L_q, mode_q, duty_q) SHALL drive generation; a pending config register SHALL hold one accepted, not-yet-applied config.
REQ-015 On transfer with en low, config SHALL become active on the next clock; cfg_ready SHALL stay high.
REQ-016 On transfer with en high, config SHALL go pending; cfg_ready SHALL drop next clock and return high the clock after the pending config is applied.
REQ-017 Pending config SHALL be applied on the clock where phase wraps from N-1 to 0, so no cycle mixes configs.
REQ-018 If transfer and wrap coincide, the offered config SHALL be applied at that wrap directly; cfg_ready SHALL remain high.
REQ-019 When en is high, step counter t SHALL reset to 0 and phase SHALL increment mod N when t >= L_q; otherwise t SHALL increment; each step therefore lasts L_q+1 clocks.
REQ-020 L_q = 0 SHALL advance phase every clock.
REQ-021 When en is low, t and phase SHALL be 0 and value SHALL be 0, cycle_start 0; a pending config SHALL be applied immediately.
REQ-022 value SHALL equal shape(phase) one clock after phase changes (latency 1).
REQ-023 Triangle, H = N/2, S = 2^OUT_W / H: p < H gives (p+1)*S-1; otherwise (N-1-p)*S.
REQ-024 Rising saw SHALL be p << (OUT_W-STEP_BITS); falling saw SHALL be (2^OUT_W-1) minus rising saw.
REQ-025 Square SHALL be 2^OUT_W-1 when p < duty_q, else 0; duty_q = 0 gives constant 0.
REQ-026 cycle_start SHALL be 1 exactly in the clock where value first shows phase 0 after a wrap, and in the first clock after en rises.
REQ-027 All arithmetic SHALL be unsigned; t SHALL be PERIOD_W bits and never wrap before reaching L_q.

Reset
REQ-028 reset SHALL force t=0, phase=0, value=0, cycle_start=0, cfg_ready=1, pending cleared.
REQ-029 Reset SHALL set the active config to L_q = 0, mode triangle, duty_q = N/2.
REQ-030 reset SHALL take priority over en and cfg_valid, including mid-cycle.

Structure
REQ-031 Package wave_gen_pkg SHALL hold the 2-bit mode enum (TRI, SAW_UP, SQUARE, SAW_DN).
REQ-032 Combinational sub-module wave_shaper (phase, mode, duty -> sample) SHALL implement REQ-023..025.

Verification
REQ-033 Defaults; cfg period=160, mode=TRI with en low; en high -> steps of 11 clocks, values 31,63,..,255,224,..,0; cycle_start every 176 clocks.
REQ-034 Mode SAW_UP, period 0 -> value 0,16,..,240 on consecutive clocks, then repeats; cycle_start every 16 clocks.
REQ-035 SQUARE, duty 4, period 32 -> 255 for 12 clocks, 0 for 36 clocks; duty 0 -> constant 0.
REQ-036 Running TRI; offer SAW_DN mid-cycle -> cfg_ready low until wrap; first SAW_DN sample 255 coincides with cycle_start.
REQ-037 Offer config on the exact wrap clock -> applied at that wrap; cfg_ready never drops.
REQ-038 Assert reset at phase 9 -> next clock value=0, cfg_ready=1, mode TRI; pending config discarded.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg
//   Shared types for the waveform generator.
//   mode_t : 2-bit waveform selector (TRI, SAW_UP, SQUARE, SAW_DN).
package wave_gen_pkg;

  typedef enum logic [1:0] {
    TRI    = 2'd0,
    SAW_UP = 2'd1,
    SQUARE = 2'd2,
    SAW_DN = 2'd3
  } mode_t;

endpackage

// File: rtl/wave_gen_if.sv
// wave_gen_if
//   Configuration channel of the waveform generator (valid/ready).
//   cfg_valid  : config offered
//   cfg_ready  : generator can take a config (no pending one waiting)
//   cfg_period : waveform cycle length in clocks
//   cfg_mode   : waveform shape
//   cfg_duty   : square-wave high-step count
//   master modport drives the offer, slave modport is the generator side.
interface wave_gen_if
  import wave_gen_pkg::*;
#(
  parameter int PERIOD_W  = 32,
  parameter int STEP_BITS = 4
);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [PERIOD_W-1:0]  cfg_period;
  mode_t                cfg_mode;
  logic [STEP_BITS-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_mode,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_mode,
    input  cfg_duty,
    output cfg_ready
  );

endinterface

// File: rtl/wave_gen_shaper.sv
// wave_shaper
//   Combinational map from step phase to output sample.
//   phase  : current step index, 0..N-1 (N = 2^STEP_BITS)
//   mode   : waveform shape
//   duty   : square-wave high-step count
//   sample : unsigned OUT_W-bit sample
module wave_shaper
  import wave_gen_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int STEP_BITS = 4
) (
  input  logic [STEP_BITS-1:0] phase,
  input  mode_t                mode,
  input  logic [STEP_BITS-1:0] duty,
  output logic [OUT_W-1:0]     sample
);

  localparam int SH = OUT_W - STEP_BITS;
  localparam logic [OUT_W-1:0] ONE  = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] LAST = {{SH{1'b0}}, {STEP_BITS{1'b1}}};

  logic [OUT_W-1:0] p_w;
  logic [OUT_W-1:0] tri_s;
  logic [OUT_W-1:0] saw_s;

  always_comb begin
    p_w   = {{SH{1'b0}}, phase};
    saw_s = {phase, {SH{1'b0}}};
    // Triangle slope is 2^OUT_W / (N/2) = 2^(SH+1). On the rising half the
    // top step computes 2^OUT_W - 1; the modular wrap of (p+1)<<(SH+1) to 0
    // followed by -1 gives exactly all-ones, so OUT_W bits suffice.
    if (!phase[STEP_BITS-1]) begin
      tri_s = ((p_w + ONE) << (SH + 1)) - ONE;
    end else begin
      tri_s = (LAST - p_w) << (SH + 1);
    end

    sample = '0;
    case (mode)
      TRI:     sample = tri_s;
      SAW_UP:  sample = saw_s;
      SQUARE:  sample = (phase < duty) ? '1 : '0;
      SAW_DN:  sample = ~saw_s;
      default: sample = '0;
    endcase
  end

endmodule

// File: rtl/wave_gen.sv
// wave_gen
//   Periodic waveform generator: N = 2^STEP_BITS steps per cycle, each step
//   lasting (cfg_period >> STEP_BITS) + 1 clocks. New configs taken while
//   running are held pending and applied only at the cycle wrap.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   en          : run enable; low holds the generator idle at phase 0
//   cfg         : configuration channel (slave side)
//   value       : registered sample
//   cycle_start : one-clock pulse with the first sample of each cycle
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int STEP_BITS = 4,
  parameter int PERIOD_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  wave_gen_if.slave        cfg,
  output logic [OUT_W-1:0] value,
  output logic             cycle_start
);

  if (OUT_W < STEP_BITS + 1) begin : g_bad_out_w
    $error("wave_gen: OUT_W must be at least STEP_BITS+1");
  end
  if (STEP_BITS < 2) begin : g_bad_step_bits
    $error("wave_gen: STEP_BITS must be at least 2");
  end

  localparam logic [PERIOD_W-1:0]  T_ONE    = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_BITS-1:0] P_ONE    = {{(STEP_BITS-1){1'b0}}, 1'b1};
  localparam logic [STEP_BITS-1:0] DUTY_DEF = {1'b1, {(STEP_BITS-1){1'b0}}};

  logic [PERIOD_W-1:0]  t;
  logic [STEP_BITS-1:0] phase;

  logic [PERIOD_W-1:0]  l_q;
  mode_t                mode_q;
  logic [STEP_BITS-1:0] duty_q;

  logic                 pend_valid;
  logic [PERIOD_W-1:0]  pend_l;
  mode_t                pend_mode;
  logic [STEP_BITS-1:0] pend_duty;

  // Phase register holds a 0 that has not yet been shown on value: set while
  // idle and for the one clock after a wrap.
  logic                 phase_fresh;

  logic                 step_done;
  logic                 wrap;
  logic                 xfer;
  logic [PERIOD_W-1:0]  offer_l;
  logic [OUT_W-1:0]     shape;

  assign step_done     = (t >= l_q);
  assign wrap          = step_done && (&phase);
  assign xfer          = cfg.cfg_valid && !pend_valid;
  assign offer_l       = cfg.cfg_period >> STEP_BITS;
  assign cfg.cfg_ready = !pend_valid;

  wave_shaper #(
    .OUT_W     (OUT_W),
    .STEP_BITS (STEP_BITS)
  ) u_shaper (
    .phase  (phase),
    .mode   (mode_q),
    .duty   (duty_q),
    .sample (shape)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      t           <= '0;
      phase       <= '0;
      value       <= '0;
      cycle_start <= 1'b0;
      phase_fresh <= 1'b1;
      pend_valid  <= 1'b0;
      pend_l      <= '0;
      pend_mode   <= TRI;
      pend_duty   <= '0;
      l_q         <= '0;
      mode_q      <= TRI;
      duty_q      <= DUTY_DEF;
    end else if (!en) begin
      t           <= '0;
      phase       <= '0;
      value       <= '0;
      cycle_start <= 1'b0;
      phase_fresh <= 1'b1;
      // Idle: nothing to keep consistent, so configs take effect at once.
      if (xfer) begin
        l_q    <= offer_l;
        mode_q <= cfg.cfg_mode;
        duty_q <= cfg.cfg_duty;
      end else if (pend_valid) begin
        l_q        <= pend_l;
        mode_q     <= pend_mode;
        duty_q     <= pend_duty;
        pend_valid <= 1'b0;
      end
    end else begin
      value       <= shape;
      cycle_start <= phase_fresh;
      phase_fresh <= wrap;

      if (step_done) begin
        t     <= '0;
        phase <= phase + P_ONE;
      end else begin
        t <= t + T_ONE;
      end

      // Config only changes together with the phase wrap so a cycle never
      // mixes two configs; an offer landing on the wrap bypasses pending.
      if (wrap) begin
        if (xfer) begin
          l_q    <= offer_l;
          mode_q <= cfg.cfg_mode;
          duty_q <= cfg.cfg_duty;
        end else if (pend_valid) begin
          l_q        <= pend_l;
          mode_q     <= pend_mode;
          duty_q     <= pend_duty;
          pend_valid <= 1'b0;
        end
      end else if (xfer) begin
        pend_l     <= offer_l;
        pend_mode  <= cfg.cfg_mode;
        pend_duty  <= cfg.cfg_duty;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen
//   Directed bench for wave_gen (OUT_W=8, STEP_BITS=4, PERIOD_W=32).
//   A vector table covers reset, enable and config handoff; hand-written
//   sequences cover whole waveform cycles, pending handoff at the wrap,
//   an offer on the wrap clock, and reset mid-cycle.
module tb_wave_gen;
  import wave_gen_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] value;
  logic       cycle_start;

  int n_tests = 0;
  int n_fail  = 0;

  wave_gen_if #(.PERIOD_W(32), .STEP_BITS(4)) cfg_bus ();

  wave_gen #(
    .OUT_W     (8),
    .STEP_BITS (4),
    .PERIOD_W  (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg         (cfg_bus.slave),
    .value       (value),
    .cycle_start (cycle_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        vld;
    logic [31:0] period;
    mode_t       mode;
    logic [3:0]  duty;
    int          exp_value;
    logic        exp_cs;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int tri_exp(input int p);
    return (p < 8) ? (p + 1) * 32 - 1 : (15 - p) * 32;
  endfunction

  task automatic set_cfg(input logic vld, input logic [31:0] period, input mode_t mode,
                         input logic [3:0] duty);
    cfg_bus.cfg_valid  = vld;
    cfg_bus.cfg_period = period;
    cfg_bus.cfg_mode   = mode;
    cfg_bus.cfg_duty   = duty;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    en    = 1'b0;
    set_cfg(1'b0, 32'd0, TRI, 4'd0);
    tick();
    reset = 1'b0;
  endtask

  // Offer a config while idle; it becomes active on this clock.
  task automatic offer_idle(input logic [31:0] period, input mode_t mode, input logic [3:0] duty);
    en = 1'b0;
    set_cfg(1'b1, period, mode, duty);
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    set_cfg(1'b0, 32'd0, TRI, 4'd0);

    //            rst   en    vld   period  mode    duty  val  cs    rdy
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd0, TRI,    4'd0,   0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'd0, SAW_UP, 4'd0,   0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0,   0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0,  16, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0,  32, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'd0, TRI,    4'd0,   0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0,   0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0,  16, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'd0, TRI,    4'd0,   0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0,  31, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0,  63, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'd0, SQUARE, 4'd4,  95, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'd0, TRI,    4'd0,   0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0, 255, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'd0, TRI,    4'd0, 255, 1'b0, 1'b1};

    tick();
    for (int i = 0; i < 15; i++) begin
      reset = vecs[i].rst;
      en    = vecs[i].en;
      set_cfg(vecs[i].vld, vecs[i].period, vecs[i].mode, vecs[i].duty);
      tick();
      check($sformatf("vec%0d value", i), 32'(value), 32'(vecs[i].exp_value));
      check($sformatf("vec%0d cycle_start", i), 32'(cycle_start), 32'(vecs[i].exp_cs));
      check($sformatf("vec%0d cfg_ready", i), 32'(cfg_bus.cfg_ready), 32'(vecs[i].exp_ready));
    end
    set_cfg(1'b0, 32'd0, TRI, 4'd0);

    // Triangle, period 160: 11-clock steps, 176-clock cycle.
    apply_reset();
    offer_idle(32'd160, TRI, 4'd8);
    en = 1'b1;
    for (int k = 1; k <= 352; k++) begin
      tick();
      check($sformatf("tri k=%0d value", k), 32'(value), 32'(tri_exp(((k - 1) / 11) % 16)));
      check($sformatf("tri k=%0d cycle_start", k), 32'(cycle_start), 32'((k - 1) % 176 == 0));
    end
    check("tri cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    // Rising saw, period 0: one step per clock.
    apply_reset();
    offer_idle(32'd0, SAW_UP, 4'd0);
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("saw k=%0d value", k), 32'(value), 32'(((k - 1) % 16) * 16));
      check($sformatf("saw k=%0d cycle_start", k), 32'(cycle_start), 32'((k - 1) % 16 == 0));
    end

    // Square duty 4, period 32: 3-clock steps, 12 high then 36 low.
    apply_reset();
    offer_idle(32'd32, SQUARE, 4'd4);
    en = 1'b1;
    for (int k = 1; k <= 96; k++) begin
      tick();
      check($sformatf("sq4 k=%0d value", k), 32'(value),
            32'((((k - 1) / 3) % 16 < 4) ? 255 : 0));
      check($sformatf("sq4 k=%0d cycle_start", k), 32'(cycle_start), 32'((k - 1) % 48 == 0));
    end

    // Square duty 0: constant low.
    apply_reset();
    offer_idle(32'd32, SQUARE, 4'd0);
    en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      check($sformatf("sq0 k=%0d value", k), 32'(value), 32'd0);
    end
    check("sq0 cycle_start", 32'(cycle_start), 32'd0);

    // Running triangle; SAW_DN offered mid-cycle waits for the wrap.
    apply_reset();
    offer_idle(32'd32, TRI, 4'd8);
    en = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      set_cfg(k == 11, 32'd32, SAW_DN, 4'd0);
      tick();
      check($sformatf("pend k=%0d value", k), 32'(value),
            32'((k <= 48) ? tri_exp(((k - 1) / 3) % 16) : 255 - 16 * ((k - 49) / 3)));
      check($sformatf("pend k=%0d cycle_start", k), 32'(cycle_start), 32'(k == 1 || k == 49));
      check($sformatf("pend k=%0d cfg_ready", k), 32'(cfg_bus.cfg_ready),
            32'(!(k >= 11 && k <= 47)));
    end
    set_cfg(1'b0, 32'd0, TRI, 4'd0);

    // Offer landing exactly on the wrap clock is applied there directly.
    apply_reset();
    offer_idle(32'd32, TRI, 4'd8);
    en = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      set_cfg(k == 48, 32'd32, SAW_UP, 4'd0);
      tick();
      check($sformatf("wrapoffer k=%0d value", k), 32'(value),
            32'((k <= 48) ? tri_exp(((k - 1) / 3) % 16) : 16 * ((k - 49) / 3)));
      check($sformatf("wrapoffer k=%0d cycle_start", k), 32'(cycle_start), 32'(k == 1 || k == 49));
      check($sformatf("wrapoffer k=%0d cfg_ready", k), 32'(cfg_bus.cfg_ready), 32'd1);
    end
    set_cfg(1'b0, 32'd0, TRI, 4'd0);

    // Reset at phase 9 with a pending SQUARE config: defaults return, pending lost.
    apply_reset();
    offer_idle(32'd32, TRI, 4'd8);
    en = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      set_cfg(k == 20 || k == 29, 32'd32, SQUARE, 4'd4);
      reset = (k == 29);
      tick();
      if (k <= 28) begin
        check($sformatf("rst k=%0d value", k), 32'(value), 32'(tri_exp(((k - 1) / 3) % 16)));
        check($sformatf("rst k=%0d cfg_ready", k), 32'(cfg_bus.cfg_ready), 32'(k < 20));
      end else if (k == 29) begin
        check("rst k=29 value", 32'(value), 32'd0);
        check("rst k=29 cycle_start", 32'(cycle_start), 32'd0);
        check("rst k=29 cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
      end else begin
        check($sformatf("rst k=%0d value", k), 32'(value), 32'(tri_exp((k - 30) % 16)));
        check($sformatf("rst k=%0d cycle_start", k), 32'(cycle_start), 32'((k - 30) % 16 == 0));
        check($sformatf("rst k=%0d cfg_ready", k), 32'(cfg_bus.cfg_ready), 32'd1);
      end
    end
    reset = 1'b0;
    set_cfg(1'b0, 32'd0, TRI, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
